// File: rtl/interpolation_unit_pkg.sv
// Shared types and constants for the bilinear interpolation feature scheduler.
package interpolation_unit_pkg;

    localparam int INT_W     = 10;
    localparam int DEC_W     = 15;
    localparam int IMG_MAX_X = 639;
    localparam int IMG_MAX_Y = 479;
    localparam int CNT_W     = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/interpolation_unit_window_addr_gen.sv
// Raster-order patch walker: column/row counters, edge clamping and last-fetch detect.
module interpolation_unit_window_addr_gen
    import interpolation_unit_pkg::*;
#(
    parameter int int_width = INT_W,
    parameter int img_max_x = IMG_MAX_X,
    parameter int img_max_y = IMG_MAX_Y
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [4:0]           wd,
    input  logic [int_width-1:0] base_x,
    input  logic [int_width-1:0] base_y,
    output logic [int_width-1:0] addr_x,
    output logic [int_width-1:0] addr_y,
    output logic                 last
);

    localparam logic [int_width:0] MAX_X = (int_width+1)'(img_max_x);
    localparam logic [int_width:0] MAX_Y = (int_width+1)'(img_max_y);

    logic [5:0]         c;
    logic [5:0]         r;
    logic [5:0]         edge_idx;
    logic [int_width:0] sum_x;
    logic [int_width:0] sum_y;

    // Patch is wd+2 wide, so the counters run 0..wd+1.
    assign edge_idx = {1'b0, wd} + 6'd1;
    assign sum_x    = {1'b0, base_x} + (int_width+1)'(c);
    assign sum_y    = {1'b0, base_y} + (int_width+1)'(r);
    assign addr_x   = (sum_x > MAX_X) ? MAX_X[int_width-1:0] : sum_x[int_width-1:0];
    assign addr_y   = (sum_y > MAX_Y) ? MAX_Y[int_width-1:0] : sum_y[int_width-1:0];
    assign last     = (c == edge_idx) && (r == edge_idx);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            c <= '0;
            r <= '0;
        end else if (enable) begin
            if (c == edge_idx) begin
                c <= '0;
                r <= last ? 6'd0 : r + 6'd1;
            end else begin
                c <= c + 6'd1;
            end
        end
    end

endmodule

// File: rtl/interpolation_unit_feature_scheduler.sv
// Steps one feature through weight load, patch fetch and output drain for the bilinear datapath.
//   state | meaning
//   IDLE  | ready for a feature, latch coordinate and window on acceptance
//   LOAD  | one-cycle frac_load strobe
//   FETCH | raster-order pixel fetches over the (wd+2)^2 patch
//   DRAIN | waiting for the remaining interpolated outputs
//   DONE  | done_val held until done_rdy
module interpolation_unit_feature_scheduler
    import interpolation_unit_pkg::*;
#(
    parameter int int_width = INT_W,
    parameter int dec_width = DEC_W,
    parameter int img_max_x = IMG_MAX_X,
    parameter int img_max_y = IMG_MAX_Y
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [4:0]                     win_dim,
    input  logic                           feat_val,
    output logic                           feat_rdy,
    input  logic [int_width+dec_width-1:0] feat_x,
    input  logic [int_width+dec_width-1:0] feat_y,
    output logic [dec_width-1:0]           frac_a,
    output logic [dec_width-1:0]           frac_b,
    output logic                           frac_load,
    output logic                           mem_val,
    input  logic                           mem_rdy,
    output logic [int_width-1:0]           mem_addr_x,
    output logic [int_width-1:0]           mem_addr_y,
    input  logic                           interp_val,
    output logic                           done_val,
    input  logic                           done_rdy
);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [4:0]           wd;
    logic [int_width-1:0] bx;
    logic [int_width-1:0] by;
    logic [CNT_W-1:0]     oc;
    logic [CNT_W-1:0]     target;
    logic [CNT_W-1:0]     side;
    logic [int_width-1:0] int_x;
    logic [int_width-1:0] int_y;
    logic [int_width-1:0] half_wd;
    logic                 accept;
    logic                 fetch_hs;
    logic                 done_hs;
    logic                 fetch_last;
    logic                 target_hit;

    assign int_x      = feat_x[dec_width +: int_width];
    assign int_y      = feat_y[dec_width +: int_width];
    assign half_wd    = int_width'(win_dim >> 1);
    assign side       = CNT_W'(win_dim) + CNT_W'(1);
    assign accept     = feat_val && feat_rdy;
    assign fetch_hs   = mem_val && mem_rdy;
    assign done_hs    = done_val && done_rdy;
    // Counts as reached on the cycle the last output arrives, not one later.
    assign target_hit = (oc == target) || (interp_val && ((oc + CNT_W'(1)) == target));

    interpolation_unit_window_addr_gen #(
        .int_width (int_width),
        .img_max_x (img_max_x),
        .img_max_y (img_max_y)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || done_hs),
        .enable (fetch_hs),
        .wd     (wd),
        .base_x (bx),
        .base_y (by),
        .addr_x (mem_addr_x),
        .addr_y (mem_addr_y),
        .last   (fetch_last)
    );

    always_comb begin
        state_nxt = state;
        feat_rdy  = 1'b0;
        frac_load = 1'b0;
        mem_val   = 1'b0;
        done_val  = 1'b0;
        case (state)
            IDLE: begin
                feat_rdy = !reset;
                if (feat_val && !reset) state_nxt = LOAD;
            end
            LOAD: begin
                frac_load = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                mem_val = 1'b1;
                if (mem_rdy && fetch_last) state_nxt = target_hit ? DONE : DRAIN;
            end
            DRAIN: begin
                if (target_hit) state_nxt = DONE;
            end
            DONE: begin
                done_val = 1'b1;
                if (done_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wd     <= '0;
            bx     <= '0;
            by     <= '0;
            frac_a <= '0;
            frac_b <= '0;
            target <= '0;
            oc     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wd     <= win_dim;
                bx     <= (int_x >= half_wd) ? int_x - half_wd : '0;
                by     <= (int_y >= half_wd) ? int_y - half_wd : '0;
                frac_a <= feat_x[dec_width-1:0];
                frac_b <= feat_y[dec_width-1:0];
                target <= side * side;
            end
            if (done_hs) begin
                oc <= '0;
            end else if (interp_val && (state != IDLE) && (oc < target)) begin
                oc <= oc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_interpolation_unit_feature_scheduler.sv
// Directed bench for the feature scheduler: fetch order, stalls, clamping, drain and reset.
module tb_interpolation_unit_feature_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  win_dim;
    logic        feat_val;
    logic        feat_rdy;
    logic [24:0] feat_x;
    logic [24:0] feat_y;
    logic [14:0] frac_a;
    logic [14:0] frac_b;
    logic        frac_load;
    logic        mem_val;
    logic        mem_rdy;
    logic [9:0]  mem_addr_x;
    logic [9:0]  mem_addr_y;
    logic        interp_val;
    logic        done_val;
    logic        done_rdy;

    int tests = 0;
    int failures = 0;

    interpolation_unit_feature_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .win_dim    (win_dim),
        .feat_val   (feat_val),
        .feat_rdy   (feat_rdy),
        .feat_x     (feat_x),
        .feat_y     (feat_y),
        .frac_a     (frac_a),
        .frac_b     (frac_b),
        .frac_load  (frac_load),
        .mem_val    (mem_val),
        .mem_rdy    (mem_rdy),
        .mem_addr_x (mem_addr_x),
        .mem_addr_y (mem_addr_y),
        .interp_val (interp_val),
        .done_val   (done_val),
        .done_rdy   (done_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] fx(input int i, input int f);
        return 25'((i << 15) | f);
    endfunction

    task automatic accept(input logic [24:0] x, input logic [24:0] y, input logic [4:0] w,
                          input int ea, input int eb);
        feat_x   = x;
        feat_y   = y;
        win_dim  = w;
        feat_val = 1'b1;
        check("feat_rdy in idle", feat_rdy, 1);
        tick();
        feat_val = 1'b0;
        win_dim  = 5'd31;
        check("frac_load strobe", frac_load, 1);
        check("frac_a", frac_a, ea);
        check("frac_b", frac_b, eb);
        check("mem_val in load", mem_val, 0);
        tick();
        check("frac_load single", frac_load, 0);
    endtask

    task automatic fetch_run(input int bx, input int by, input int wd, input bit bp);
        int total;
        int n;
        int cyc;
        int ex;
        int ey;
        logic [9:0] px;
        logic [9:0] py;
        bit stalled;
        total   = (wd + 2) * (wd + 2);
        n       = 0;
        cyc     = 0;
        stalled = 1'b0;
        px      = '0;
        py      = '0;
        while (n < total && cyc < 5000) begin
            mem_rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check("mem_val in fetch", mem_val, 1);
            if (stalled) begin
                check("hold addr_x", mem_addr_x, px);
                check("hold addr_y", mem_addr_y, py);
            end
            if (mem_rdy) begin
                ex = bx + n % (wd + 2);
                ey = by + n / (wd + 2);
                if (ex > 639) ex = 639;
                if (ey > 479) ey = 479;
                check("addr_x", mem_addr_x, ex);
                check("addr_y", mem_addr_y, ey);
                n++;
            end
            stalled = !mem_rdy;
            px = mem_addr_x;
            py = mem_addr_y;
            tick();
            cyc++;
        end
        mem_rdy = 1'b0;
        check("fetch count", n, total);
        if (!bp) check("fetch cycles", cyc, total);
        check("mem_val after fetch", mem_val, 0);
    endtask

    task automatic finish_feature(input int target, input int hold);
        interp_val = 1'b1;
        repeat (target - 1) tick();
        interp_val = 1'b0;
        check("done_val before last output", done_val, 0);
        interp_val = 1'b1;
        tick();
        interp_val = 1'b0;
        check("done_val after last output", done_val, 1);
        repeat (hold) begin
            tick();
            check("done_val held", done_val, 1);
            check("feat_rdy in done", feat_rdy, 0);
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        check("done_val cleared", done_val, 0);
        check("feat_rdy back in idle", feat_rdy, 1);
    endtask

    initial begin
        reset      = 1'b1;
        win_dim    = '0;
        feat_val   = 1'b0;
        feat_x     = '0;
        feat_y     = '0;
        mem_rdy    = 1'b0;
        interp_val = 1'b0;
        done_rdy   = 1'b0;

        tick();
        check("reset feat_rdy", feat_rdy, 0);
        check("reset mem_val", mem_val, 0);
        check("reset done_val", done_val, 0);
        check("reset frac_load", frac_load, 0);
        check("reset frac_a", frac_a, 0);
        check("reset frac_b", frac_b, 0);
        reset = 1'b0;
        tick();
        check("feat_rdy after reset", feat_rdy, 1);

        // Outputs seen while idle must not count toward the next feature.
        interp_val = 1'b1;
        repeat (3) tick();
        interp_val = 1'b0;

        accept(fx(100, 16'h4000), fx(50, 16'h2000), 5'd3, 16'h4000, 16'h2000);
        fetch_run(99, 49, 3, 1'b0);
        feat_x   = fx(5, 16'h1111);
        feat_val = 1'b1;
        check("feat_rdy while busy", feat_rdy, 0);
        tick();
        feat_val = 1'b0;
        check("frac_a kept while busy", frac_a, 16'h4000);
        finish_feature(16, 0);

        accept(fx(100, 16'h4000), fx(50, 16'h2000), 5'd3, 16'h4000, 16'h2000);
        fetch_run(99, 49, 3, 1'b1);
        finish_feature(16, 5);

        accept(fx(200, 16'h0001), fx(300, 16'h7fff), 5'd0, 16'h0001, 16'h7fff);
        fetch_run(200, 300, 0, 1'b0);
        check("min window draining", done_val, 0);
        finish_feature(1, 0);

        accept(fx(0, 0), fx(0, 0), 5'd7, 0, 0);
        interp_val = 1'b1;
        fetch_run(0, 0, 7, 1'b0);
        interp_val = 1'b0;
        check("target met at fetch end", done_val, 1);
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        check("idle after direct done", feat_rdy, 1);

        accept(fx(639, 16'h0100), fx(479, 16'h0200), 5'd3, 16'h0100, 16'h0200);
        fetch_run(638, 478, 3, 1'b0);
        finish_feature(16, 0);

        accept(fx(10, 16'h1234), fx(20, 16'h0abc), 5'd4, 16'h1234, 16'h0abc);
        mem_rdy = 1'b1;
        repeat (10) tick();
        reset   = 1'b1;
        mem_rdy = 1'b0;
        tick();
        check("mid reset mem_val", mem_val, 0);
        check("mid reset done_val", done_val, 0);
        check("mid reset frac_load", frac_load, 0);
        check("mid reset frac_a", frac_a, 0);
        check("mid reset frac_b", frac_b, 0);
        check("mid reset feat_rdy", feat_rdy, 0);
        reset = 1'b0;
        tick();
        check("feat_rdy after mid reset", feat_rdy, 1);
        accept(fx(10, 16'h1234), fx(20, 16'h0abc), 5'd4, 16'h1234, 16'h0abc);
        fetch_run(8, 18, 4, 1'b0);
        finish_feature(25, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/interpolation_unit_feature_scheduler.md
Name: interpolation_unit_feature_scheduler

Overview:
- Sequences one feature point at a time through the bilinear interpolation datapath.
- Accepts a fixed-point feature coordinate and splits it into integer base and fractional weights (a, b).
- Pulses the weight-load strobe, then issues raster-order pixel fetches covering a (win_dim+2)x(win_dim+2) source patch. The +1 row and +1 column supply the bilinear neighbours.
- Counts interpolated outputs, then reports completion through a val/rdy done interface.

Parameters:
int_width, 10, integer bits of a coordinate; also the pixel address width
dec_width, 15, fractional bits of a coordinate; also the width of frac_a/frac_b
img_max_x, 639, largest legal column address
img_max_y, 479, largest legal row address

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
win_dim  in  5  window dimension minus one; sampled on feature acceptance
feat_val  in  1  feature request valid
feat_rdy  out  1  scheduler ready for a feature
feat_x  in  int_width+dec_width  feature x, unsigned fixed point
feat_y  in  int_width+dec_width  feature y, unsigned fixed point
frac_a  out  dec_width  fractional part of x (held)
frac_b  out  dec_width  fractional part of y (held)
frac_load  out  1  one-cycle strobe: datapath loads a, b, 1-a, 1-b
mem_val  out  1  pixel fetch valid
mem_rdy  in  1  pixel fetch accepted
mem_addr_x  out  int_width  fetch column
mem_addr_y  out  int_width  fetch row
interp_val  in  1  one interpolated pixel produced by the datapath
done_val  out  1  feature complete
done_rdy  in  1  consumer accepts completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE; all counters 0; frac_a=0, frac_b=0; feat_rdy=0 during the reset cycle; frac_load=0, mem_val=0, done_val=0. Reset asserted mid-operation abandons the feature with no done. Fetches already issued are not retracted.
- States: IDLE, LOAD, FETCH, DRAIN, DONE.
- IDLE:
  - feat_rdy=1.
  - On feat_val, latch win_dim into wd, and latch the integer and fractional fields of both coordinates.
  - Base coordinate: bx = int(x) - (wd>>1), by = int(y) - (wd>>1), clamped to 0 on underflow.
  - Go to LOAD.
- LOAD:
  - frac_load=1 for exactly one cycle.
  - frac_a/frac_b are valid from this cycle until the next acceptance.
  - Go to FETCH.
- FETCH:
  - mem_val=1.
  - Address is (bx+c, by+r), each coordinate clamped to img_max_x / img_max_y. Clamping repeats the edge pixel.
  - c and r are 6-bit counters, range 0..wd+1.
  - On mem_val&&mem_rdy, c increments. At c==wd+1, c wraps to 0 and r increments.
  - At c==wd+1 && r==wd+1 with a handshake, go to DRAIN.
  - When mem_rdy=0, the address and mem_val hold stable.
- Output counting:
  - An 11-bit output counter oc increments on every cycle in which interp_val=1, in any non-IDLE state.
  - Target count is (wd+1)^2, computed at acceptance.
- DRAIN: when oc reaches the target, or on the cycle it becomes equal, go to DONE.
  - If the target is already reached when FETCH completes, go FETCH->DONE directly.
- DONE:
  - done_val=1 until done_rdy. On the handshake, go to IDLE and clear oc, c and r.
  - feat_rdy is 0 in DONE; there is no same-cycle accept.
- Boundaries:
  - wd=0 gives a 2x2 fetch (4 requests) and a target of 1.
  - wd=31 gives a 33x33 fetch (1089 requests) and a target of 1024.
  - interp_val in IDLE is ignored.
  - interp_val beyond the target is ignored (saturate at target).
  - feat_val while busy is not accepted.
- Latency:
  - Acceptance to frac_load: 1 cycle.
  - Acceptance to first mem_val: 2 cycles.
  - With mem_rdy held at 1, FETCH lasts exactly (wd+2)^2 cycles.

Decomposition:
- Shared package interpolation_unit_pkg holds:
  - the state enum (IDLE..DONE);
  - constants INT_W=10, DEC_W=15, IMG_MAX_X=639, IMG_MAX_Y=479;
  - the target-count width (11).
- One sub-module: interpolation_unit_window_addr_gen. It contains the c/r counters, the clamp logic and the last-fetch detect. It has enable and clear inputs and outputs addr_x, addr_y and last.

Test Plan:
- Basic fetch: wd=3, feat_x=(100<<15)|0x4000, feat_y=(50<<15)|0x2000, mem_rdy=1.
  - Expect frac_a=0x4000, frac_b=0x2000, and frac_load one cycle after acceptance.
  - Expect 25 fetches from (99,49) to (103,53) in raster order.
  - Drive 16 interp_val pulses; expect done_val after the 16th.
- Backpressure: same feature with mem_rdy toggling 1,0,0,1.
  - Expect the address held stable while stalled.
  - Expect exactly 25 handshakes with no duplicate or skipped addresses.
- Clamping:
  - Feature at int (0,0) with wd=7 gives base (0,0) with no underflow wrap.
  - Feature at int (639,479) gives all columns beyond 639 fetched as 639 and all rows beyond 479 fetched as 479.
- Minimum window: wd=0.
  - Expect 4 fetches, (x,y), (x+1,y), (x,y+1), (x+1,y+1).
  - Expect one interp_val followed by done_val.
- Done backpressure and back-to-back features:
  - Hold done_rdy=0 for 5 cycles; done_val stays high and feat_rdy stays 0.
  - Release done_rdy; the next feature is accepted in IDLE on the following cycle.
- Reset mid-FETCH: assert reset after the 10th fetch with wd=4.
  - Next cycle: mem_val=0, done_val=0, frac_load=0, frac_a=frac_b=0.
  - feat_rdy=1 once reset deasserts.
  - A new feature restarts its fetch at c=0, r=0.
